// File: rtl/spi_slave_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx_fifo
// Description : Receive-only SPI slave with a show-ahead receive FIFO.
//               - CS, SCL and MOSI are asynchronous pins. Each one passes
//                 through a two-flop synchronizer. A third SCL flop is used
//                 for edge detection.
//               - MSB-first words of WIDTH bits are assembled on the selected
//                 SCL sample edge. Any number of contiguous words can be sent
//                 in one CS frame.
//               - Completed words are pushed into a 2**DEPTH_LOG2 entry FIFO.
//                 The FIFO head is presented combinationally on rx_data.
//
// Ports       : clk        system clock (must be at least 4x SCL)
//               resetq     asynchronous active-low reset
//               CS         chip select pin, high = selected
//               SCL        SPI clock pin
//               MOSI       SPI data pin, MSB first
//               rx_data    FIFO head word, valid while rx_valid = 1
//               rx_valid   FIFO not empty
//               rx_ready   consumer pops the head when rx_valid is also high
//               count      number of words held, 0 .. 2**DEPTH_LOG2
//               overflow   sticky flag: a word arrived while the FIFO was full
//               ovf_clr    one-cycle pulse that clears overflow
//               frame_err  one-cycle pulse: CS dropped mid-word
//
// Config      : SPISLAVE_FRESHEN_EN (macro)
//               defined   - a push into a full FIFO flushes it and keeps only
//                           the new word
//               undefined - a push into a full FIFO drops the new word
//
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  CS,
    input  logic                  SCL,
    input  logic                  MOSI,
    output logic [WIDTH-1:0]      rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  frame_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  c_CNT_W     = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST_BIT  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_BIT_ONE   = c_CNT_W'(1);
    localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    // Modes 0 and 3 (CPOL == CPHA) sample on the rising SCL edge.
    // Modes 1 and 2 sample on the falling SCL edge.
    localparam bit                  c_SAMPLE_RISE = (CPOL == CPHA);

    // ------------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------------
    logic r_cs_s1,   r_cs_s2;
    logic r_scl_s1,  r_scl_s2,  r_scl_s3;
    logic r_mosi_s1, r_mosi_s2;

    // r_live_s* fill with ones after reset. Only once r_live_s2 is set does
    // r_cs_s2 reflect the real pin rather than its cleared reset value.
    logic r_live_s1, r_live_s2;

    // Set after CS has really been seen low following reset. If reset is
    // released in the middle of a frame, that frame is ignored.
    logic r_armed;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_scl_s1  <= 1'b0;
            r_scl_s2  <= 1'b0;
            r_scl_s3  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_live_s1 <= 1'b0;
            r_live_s2 <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_cs_s1   <= CS;
            r_cs_s2   <= r_cs_s1;
            r_scl_s1  <= SCL;
            r_scl_s2  <= r_scl_s1;
            r_scl_s3  <= r_scl_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
            r_live_s1 <= 1'b1;
            r_live_s2 <= r_live_s1;
            if (r_live_s2 && !r_cs_s2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // The edge is seen between stages 2 and 3. MOSI stage 2 holds the data
    // that was on the pin when stage-1 SCL captured the new level.
    logic w_sample_edge;
    logic w_active;

    assign w_sample_edge = c_SAMPLE_RISE ? (r_scl_s2 & ~r_scl_s3)
                                         : (~r_scl_s2 & r_scl_s3);
    assign w_active      = r_armed & r_cs_s2;

    // ------------------------------------------------------------------------
    // Bit assembly
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_bitcnt;
    logic [WIDTH-2:0]   r_shift;      // the bits received so far (WIDTH-1 at most)
    logic               r_push;       // one-cycle push request to the FIFO
    logic [WIDTH-1:0]   r_push_data;
    logic               r_frame_err;
    logic [WIDTH-1:0]   w_shift_next;

    assign w_shift_next = {r_shift, r_mosi_s2};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            if (!w_active) begin
                // Deselected: a partial word is dropped and reported. The
                // counter clears, so the pulse lasts exactly one cycle.
                r_frame_err <= (r_bitcnt != '0);
                r_bitcnt    <= '0;
                r_shift     <= '0;
            end else if (w_sample_edge) begin
                if (r_bitcnt == c_LAST_BIT) begin
                    // Word complete. Restart at once so the next word can
                    // follow in the same frame.
                    r_push      <= 1'b1;
                    r_push_data <= w_shift_next;
                    r_bitcnt    <= '0;
                    r_shift     <= '0;
                end else begin
                    r_shift  <= w_shift_next[WIDTH-2:0];
                    r_bitcnt <= r_bitcnt + c_BIT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_ovf_event;
    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL);
    assign w_pop       = rx_ready & ~w_empty;
    // If a pop happens in the same cycle, it frees the slot. A push into a
    // full FIFO with a simultaneous pop is therefore not an overrun.
    assign w_ovf_event = r_push & w_full & ~w_pop;

    always_comb begin
        w_mem_we     = 1'b0;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (r_push && (!w_full || w_pop)) begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
            end else begin
                w_count_nxt  = r_count + c_CNT_ONE;
            end
        end else if (w_ovf_event) begin
`ifdef SPISLAVE_FRESHEN_EN
            // Flush the stale contents. The new word becomes the only entry,
            // so the consumer never reads data older than the overrun.
            w_mem_we     = 1'b1;
            w_rd_ptr_nxt = r_wr_ptr;
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
            w_count_nxt  = c_CNT_ONE;
`else
            // The new word is discarded. Stored contents stay untouched.
            w_mem_we     = 1'b0;
`endif
        end else if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
            w_count_nxt  = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            // A new overrun takes priority over a clear in the same cycle.
            if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // The storage array has no reset. Its contents are never visible while
    // the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rx_valid  = ~w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
